core_clk_en_ctrl: RTL and testbench
===================================

# core_clk_en_ctrl

Cluster-side responder to the core's sleep handshake. It observes `core_sleep_i` and drives the core's `pulp_clock_en_i` (`clock_en_o`). It buffers wake events while the core clock is disabled and releases interrupt/debug requests only after a programmable wake-up delay. This keeps the core-side environment guarantees intact: clock enabled whenever the core is not sleeping, and no irq/debug presented while the clock is disabled.

## Interface
- `NUM_EVT`, 8: number of event lines (1..32).
- `WAKE_CYCLES`, 2: cycles `clock_en_o` is high before irq/debug are released (1..15).
- `MASK_RST`, `'0`: reset value of the event mask.
- `clk_i`  in  1  free-running clock (ungated).
- `rst_i`  in  1  synchronous, active-high reset.
- `core_sleep_i`  in  1  core sleep indication.
- `clock_en_o`  out  1  core clock enable; drives core `pulp_clock_en_i`.
- `evt_i`  in  NUM_EVT  event pulses; each high cycle sets the matching pending bit.
- `evt_clr_i`  in  NUM_EVT  clear strobes for pending bits.
- `mask_we_i`  in  1  mask write strobe.
- `mask_wdata_i`  in  NUM_EVT  new mask value.
- `pending_o`  out  NUM_EVT  pending register.
- `mask_o`  out  NUM_EVT  mask register.
- `debug_req_i`  in  1  external debug request (level).
- `debug_req_o`  out  1  debug request to core.
- `irq_o`  out  1  wake/event interrupt to core.
- `asleep_o`  out  1  FSM in SLEEP.
- `sleep_cycles_o`  out  32  sleep cycle counter (see Configuration).

## Operation
- Registers: `state_q` {RUN, SLEEP, WAKE}, `pending_q`, `mask_q`, `wcnt_q` (4 bits).
- `pending_d = (pending_q & ~evt_clr_i) | evt_i`. Set wins over clear on the same bit.
- `mask_q` is loaded from `mask_wdata_i` when `mask_we_i` is high.
- `wake_src = |(pending_q & mask_q) | debug_req_i | !core_sleep_i`.
- `release = (state_q == RUN)`.
- `irq_o = release & |(pending_q & mask_q)`.
- `debug_req_o = release & debug_req_i`.
- `clock_en_o = (state_q != SLEEP) | !core_sleep_i`. This combinational override guarantees `core_sleep_i == 0` implies `clock_en_o == 1`.
- `asleep_o = (state_q == SLEEP)`.
- RUN:
  - if `core_sleep_i & !(|(pending_q & mask_q)) & !debug_req_i`, go to SLEEP;
  - otherwise stay in RUN.
- SLEEP:
  - if `wake_src`, go to WAKE and load `wcnt_q = WAKE_CYCLES - 1`;
  - otherwise stay in SLEEP.
- WAKE:
  - if `wcnt_q == 0`, go to RUN;
  - otherwise decrement `wcnt_q`.
  - Event accumulation continues in every state.
- Reset values (registered state and `sleep_cycles_o`; other outputs follow from the equations above):
  - `state_q` = RUN, so `clock_en_o` = 1 and `asleep_o` = 0.
  - `pending_q` = 0, so `irq_o` = 0.
  - `mask_q` = MASK_RST.
  - `wcnt_q` = 0.
  - `sleep_cycles_o` = 0.
  - `debug_req_o` = `debug_req_i` (state is RUN).
- Reset asserted mid-operation (SLEEP or WAKE): the FSM is in RUN at the next edge and `pending_q` is cleared; `clock_en_o` is high from that edge.

## Timing
- Sleep entry: `core_sleep_i` high with no wake source at edge t → SLEEP from t+1; `clock_en_o` low from t+1 (subject to the override).
- Wake: wake source in SLEEP sampled at edge t → WAKE at t+1 with `clock_en_o` = 1. State is RUN at t+1+WAKE_CYCLES, so `irq_o`/`debug_req_o` can first be high then.
- An event arriving in the same cycle as the RUN→SLEEP decision does not block entry. It is already in `pending_q` one cycle later and wakes the block from SLEEP.
- `core_sleep_i` falling while in SLEEP: `clock_en_o` rises in the same cycle (combinational), then the FSM follows the WAKE path.
- `irq_o` is low in every cycle in which `clock_en_o` is low.

## Configuration
- `CORE_CLK_EN_CTRL_STATS_EN` defined:
  - `sleep_cycles_o` is a 32-bit counter, incremented on every cycle with `state_q == SLEEP`;
  - it saturates at 0xFFFFFFFF and is cleared only by `rst_i`.
- Not defined: `sleep_cycles_o` is tied to 0 and no counter logic is instantiated.

## Test plan
- Reset release:
  - after reset, `clock_en_o` = 1, `irq_o` = 0, `asleep_o` = 0 and `mask_o` = MASK_RST;
  - `core_sleep_i` = 1 with no events → `asleep_o` = 1 and `clock_en_o` = 0 exactly one cycle later.
- Masked wake, WAKE_CYCLES = 2:
  - mask = 0x01 while in SLEEP; pulse `evt_i` = 0x01 at edge t;
  - `pending_o` = 0x01 from t+1; SLEEP→WAKE decision at t+1, so WAKE from t+2;
  - `clock_en_o` = 1 at t+2; `irq_o` = 1 first at t+4.
- Unmasked event:
  - mask = 0x00, `evt_i` = 0x80 during SLEEP → `pending_o` = 0x80, state stays SLEEP, `clock_en_o` = 0;
  - write mask = 0x80 → wake follows.
- Set/clear collision: `evt_i` = 0x04 and `evt_clr_i` = 0x04 in the same cycle → `pending_o[2]` = 1; `evt_clr_i` = 0x04 alone → 0.
- Debug and override:
  - `debug_req_i` = 1 in SLEEP → `debug_req_o` stays 0 during WAKE and goes high on reaching RUN;
  - dropping `core_sleep_i` in SLEEP forces `clock_en_o` = 1 in the same cycle.
- Reset mid-WAKE: assert `rst_i` → next edge state = RUN, `pending_o` = 0, `clock_en_o` = 1; with the macro on, `sleep_cycles_o` = 0.

Source files
------------

// File: rtl/core_clk_en_ctrl_if.sv
// core_clk_en_ctrl_if: sleep handshake, event, mask and debug signals between the core side and the clock-enable controller
interface core_clk_en_ctrl_if #(parameter int NUM_EVT = 8);
  logic core_sleep_i;
  logic clock_en_o;
  logic [NUM_EVT-1:0] evt_i;
  logic [NUM_EVT-1:0] evt_clr_i;
  logic mask_we_i;
  logic [NUM_EVT-1:0] mask_wdata_i;
  logic [NUM_EVT-1:0] pending_o;
  logic [NUM_EVT-1:0] mask_o;
  logic debug_req_i;
  logic debug_req_o;
  logic irq_o;
  logic asleep_o;
  logic [31:0] sleep_cycles_o;
  modport slave (
    input  core_sleep_i, evt_i, evt_clr_i, mask_we_i, mask_wdata_i, debug_req_i,
    output clock_en_o, pending_o, mask_o, debug_req_o, irq_o, asleep_o, sleep_cycles_o
  );
  modport master (
    output core_sleep_i, evt_i, evt_clr_i, mask_we_i, mask_wdata_i, debug_req_i,
    input  clock_en_o, pending_o, mask_o, debug_req_o, irq_o, asleep_o, sleep_cycles_o
  );
endinterface

// File: rtl/core_clk_en_ctrl.sv
// core_clk_en_ctrl: core clock-enable/sleep responder with event buffering; CORE_CLK_EN_CTRL_STATS_EN adds a saturating sleep-cycle counter
module core_clk_en_ctrl #(
  parameter int NUM_EVT = 8,
  parameter int WAKE_CYCLES = 2,
  parameter logic [NUM_EVT-1:0] MASK_RST = '0
) (
  input logic clk_i,
  input logic rst_i,
  core_clk_en_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, SLEEP, WAKE} state_t;
  state_t state_q;
  logic [NUM_EVT-1:0] pending_q, mask_q;
  logic [3:0] wcnt_q;
  logic evt_hit, wake_src, release_ok;
  assign evt_hit = |(pending_q & mask_q);
  assign wake_src = evt_hit | bus.debug_req_i | !bus.core_sleep_i;
  assign release_ok = state_q == RUN;
  assign bus.irq_o = release_ok & evt_hit;
  assign bus.debug_req_o = release_ok & bus.debug_req_i;
  // override keeps the core clocked whenever it is not asking to sleep
  assign bus.clock_en_o = state_q != SLEEP || !bus.core_sleep_i;
  assign bus.asleep_o = state_q == SLEEP;
  assign bus.pending_o = pending_q;
  assign bus.mask_o = mask_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      pending_q <= '0;
      mask_q <= MASK_RST;
      wcnt_q <= '0;
    end else begin
      pending_q <= (pending_q & ~bus.evt_clr_i) | bus.evt_i;
      if (bus.mask_we_i) mask_q <= bus.mask_wdata_i;
      case (state_q)
        RUN: if (bus.core_sleep_i && !evt_hit && !bus.debug_req_i) state_q <= SLEEP;
        SLEEP: if (wake_src) begin
          state_q <= WAKE;
          wcnt_q <= 4'(WAKE_CYCLES - 1);
        end
        WAKE: if (wcnt_q == '0) state_q <= RUN; else wcnt_q <= wcnt_q - 4'd1;
        default: state_q <= RUN;
      endcase
    end
  end
`ifdef CORE_CLK_EN_CTRL_STATS_EN
  logic [31:0] sleep_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) sleep_cnt_q <= '0;
    else if (state_q == SLEEP && sleep_cnt_q != '1) sleep_cnt_q <= sleep_cnt_q + 32'd1;
  end
  assign bus.sleep_cycles_o = sleep_cnt_q;
`else
  assign bus.sleep_cycles_o = '0;
`endif
endmodule

// File: tb/tb_core_clk_en_ctrl.sv
// tb_core_clk_en_ctrl: directed scenarios plus random traffic against a timestamp-based reference model
module tb_core_clk_en_ctrl;
  localparam int N = 8;
  localparam int W = 2;
  localparam logic [N-1:0] MRST = '0;
  logic clk = 0;
  logic rst = 1;
  int errs = 0;
  int checks = 0;
  core_clk_en_ctrl_if #(.NUM_EVT(N)) bus ();
  core_clk_en_ctrl #(.NUM_EVT(N), .WAKE_CYCLES(W), .MASK_RST(MRST)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  // reference: asleep flag plus the cycle number at which irq/debug may be released
  logic [N-1:0] m_pend, m_mask;
  bit m_asleep;
  int cyc = 0;
  int m_rel = 0;
  logic [31:0] m_stat;
  task automatic model_edge();
    bit hit;
    bit run;
    hit = |(m_pend & m_mask);
    run = !m_asleep && cyc >= m_rel;
    cyc++;
    if (rst) begin
      m_pend = '0; m_mask = MRST; m_asleep = 0; m_rel = 0; m_stat = '0;
    end else begin
      if (m_asleep && m_stat != 32'hFFFF_FFFF) m_stat++;
      if (run && bus.core_sleep_i && !hit && !bus.debug_req_i) m_asleep = 1;
      else if (m_asleep && (hit || bus.debug_req_i || !bus.core_sleep_i)) begin
        m_asleep = 0;
        m_rel = cyc + W;
      end
      m_pend = (m_pend & ~bus.evt_clr_i) | bus.evt_i;
      if (bus.mask_we_i) m_mask = bus.mask_wdata_i;
    end
  endtask
  function automatic logic [51:0] mdl();
    bit run;
    logic [31:0] st;
    run = !m_asleep && cyc >= m_rel;
`ifdef CORE_CLK_EN_CTRL_STATS_EN
    st = m_stat;
`else
    st = '0;
`endif
    return {!m_asleep || !bus.core_sleep_i, run && |(m_pend & m_mask), run && bus.debug_req_i, m_asleep, m_pend, m_mask, st};
  endfunction
  function automatic logic [51:0] obs();
    return {bus.clock_en_o, bus.irq_o, bus.debug_req_o, bus.asleep_o, bus.pending_o, bus.mask_o, bus.sleep_cycles_o};
  endfunction
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus.evt_i = '0;
    bus.evt_clr_i = '0;
    bus.mask_we_i = 0;
  endtask
  task automatic go_sleep();
    bus.core_sleep_i = 1; bus.debug_req_i = 0;
    bus.evt_clr_i = '1; bus.mask_we_i = 1; bus.mask_wdata_i = '0;
    tick(); tick(); tick();
  endtask
  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if (obs() !== mdl()) begin errs++; $display("FAIL reset_vec got=%h exp=%h", obs(), mdl()); end
    checks++; if ({bus.clock_en_o, bus.irq_o, bus.asleep_o} !== 3'b100) begin errs++; $display("FAIL reset_outs got=%b exp=100", {bus.clock_en_o, bus.irq_o, bus.asleep_o}); end
    checks++; if (bus.mask_o !== MRST) begin errs++; $display("FAIL reset_mask got=%h exp=%h", bus.mask_o, MRST); end
    rst = 0;
    bus.core_sleep_i = 1;
    tick();
    checks++; if ({bus.asleep_o, bus.clock_en_o} !== 2'b10) begin errs++; $display("FAIL sleep_entry got=%b exp=10", {bus.asleep_o, bus.clock_en_o}); end
    checks++; if (obs() !== mdl()) begin errs++; $display("FAIL sleep_entry_vec got=%h exp=%h", obs(), mdl()); end
  endtask
  task automatic test_masked_wake();
    logic [3:0] seq;
    go_sleep();
    bus.mask_we_i = 1; bus.mask_wdata_i = 8'h01;
    tick();
    bus.evt_i = 8'h01;
    tick();
    checks++; if ({bus.pending_o, bus.asleep_o, bus.clock_en_o} !== {8'h01, 2'b10}) begin errs++; $display("FAIL mw_pending got=%h/%b exp=01/10", bus.pending_o, {bus.asleep_o, bus.clock_en_o}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = bus.irq_o;
      checks++; if (obs() !== mdl()) begin errs++; $display("FAIL mw_vec%0d got=%h exp=%h", i, obs(), mdl()); end
      if (i == 0) begin
        checks++; if ({bus.clock_en_o, bus.asleep_o} !== 2'b10) begin errs++; $display("FAIL mw_wake got=%b exp=10", {bus.clock_en_o, bus.asleep_o}); end
      end
    end
    checks++; if (seq[2:0] !== 3'b100) begin errs++; $display("FAIL mw_irq_seq got=%b exp=100", seq[2:0]); end
  endtask
  task automatic test_unmasked();
    go_sleep();
    bus.evt_i = 8'h80;
    tick(); tick();
    checks++; if ({bus.pending_o, bus.asleep_o, bus.clock_en_o} !== {8'h80, 2'b10}) begin errs++; $display("FAIL um_hold got=%h/%b exp=80/10", bus.pending_o, {bus.asleep_o, bus.clock_en_o}); end
    bus.mask_we_i = 1; bus.mask_wdata_i = 8'h80;
    tick(); tick();
    checks++; if ({bus.asleep_o, bus.clock_en_o} !== 2'b01) begin errs++; $display("FAIL um_wake got=%b exp=01", {bus.asleep_o, bus.clock_en_o}); end
    checks++; if (obs() !== mdl()) begin errs++; $display("FAIL um_vec got=%h exp=%h", obs(), mdl()); end
  endtask
  task automatic test_set_clear();
    bus.evt_clr_i = '1; tick();
    bus.evt_i = 8'h04; bus.evt_clr_i = 8'h04;
    tick();
    checks++; if (bus.pending_o[2] !== 1'b1) begin errs++; $display("FAIL sc_collide got=%b exp=1", bus.pending_o[2]); end
    bus.evt_clr_i = 8'h04;
    tick();
    checks++; if (bus.pending_o[2] !== 1'b0) begin errs++; $display("FAIL sc_clear got=%b exp=0", bus.pending_o[2]); end
  endtask
  task automatic test_debug_override();
    logic [2:0] d;
    go_sleep();
    bus.debug_req_i = 1;
    #1;
    checks++; if (bus.debug_req_o !== 1'b0) begin errs++; $display("FAIL dbg_sleep got=%b exp=0", bus.debug_req_o); end
    for (int i = 0; i < 3; i++) begin tick(); d[i] = bus.debug_req_o; end
    checks++; if (d !== 3'b100) begin errs++; $display("FAIL dbg_seq got=%b exp=100", d); end
    checks++; if (obs() !== mdl()) begin errs++; $display("FAIL dbg_vec got=%h exp=%h", obs(), mdl()); end
    go_sleep();
    bus.core_sleep_i = 0;
    #1;
    checks++; if ({bus.clock_en_o, bus.asleep_o} !== 2'b11) begin errs++; $display("FAIL override got=%b exp=11", {bus.clock_en_o, bus.asleep_o}); end
    tick();
  endtask
  task automatic test_reset_mid_wake();
    go_sleep();
    tick(); tick();
    bus.mask_we_i = 1; bus.mask_wdata_i = 8'h10; bus.evt_i = 8'h10;
    tick(); tick();
    checks++; if ({bus.asleep_o, bus.clock_en_o, bus.irq_o} !== 3'b010) begin errs++; $display("FAIL rmw_inwake got=%b exp=010", {bus.asleep_o, bus.clock_en_o, bus.irq_o}); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if ({bus.pending_o, bus.clock_en_o, bus.asleep_o, bus.sleep_cycles_o} !== {8'h00, 2'b10, 32'd0}) begin errs++; $display("FAIL rmw_reset got=%h/%b/%0d exp=00/10/0", bus.pending_o, {bus.clock_en_o, bus.asleep_o}, bus.sleep_cycles_o); end
    checks++; if (obs() !== mdl()) begin errs++; $display("FAIL rmw_vec got=%h exp=%h", obs(), mdl()); end
  endtask
  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      bus.core_sleep_i = ($urandom % 8) != 0;
      bus.evt_i = ($urandom % 6 == 0) ? N'(1 << ($urandom % N)) : '0;
      bus.evt_clr_i = ($urandom % 4 == 0) ? N'($urandom) : '0;
      bus.mask_we_i = ($urandom % 10) == 0;
      bus.mask_wdata_i = N'($urandom);
      bus.debug_req_i = ($urandom % 12) == 0;
      rst = ($urandom % 150) == 0;
      #1;
      checks++; if (obs() !== mdl()) begin errs++; if (bad++ < 10) $display("FAIL rnd_comb cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
      tick();
      checks++; if (obs() !== mdl()) begin errs++; if (bad++ < 10) $display("FAIL rnd_edge cyc=%0d got=%h exp=%h", i, obs(), mdl()); end
    end
    rst = 0;
  endtask
  initial begin
    bus.core_sleep_i = 0; bus.evt_i = '0; bus.evt_clr_i = '0;
    bus.mask_we_i = 0; bus.mask_wdata_i = '0; bus.debug_req_i = 0;
    m_pend = '0; m_mask = MRST; m_asleep = 0; m_stat = '0;
    test_reset();
    test_masked_wake();
    test_unmasked();
    test_set_clear();
    test_debug_override();
    test_reset_mid_wake();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
